// File: rtl/bcd_scan_display.sv
// Time-multiplexed 6-digit 7-segment driver for packed BCD hh:mm:ss.
// Inputs are snapshotted once per scan frame; supports blink, colon dp, ghost blanking, dash glyph.
module bcd_scan_display #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLANK_CYC    = 500,
  parameter int unsigned BLINK_FRAMES = 60,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] hour,
  input  logic [7:0] min,
  input  logic [7:0] sec,
  input  logic [5:0] blink_mask,
  input  logic       colon_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic        INV   = (ACTIVE_LOW != 0);

  logic [PRE_W-1:0] pre_q, pre_d;
  logic [2:0]       idx_q, idx_d;
  logic [FRM_W-1:0] frame_q, frame_d;
  logic             bp_q, bp_d;
  logic [7:0]       snap_hour_q, snap_hour_d;
  logic [7:0]       snap_min_q, snap_min_d;
  logic [7:0]       snap_sec_q, snap_sec_d;
  logic [5:0]       snap_mask_q, snap_mask_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [5:0]       an_q, an_d;
  logic             pre_wrap, frame_end, lit, mask_bit;
  logic [3:0]       nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // Prescaler, digit index, frame/blink counters and per-frame snapshot.
  always_comb begin
    pre_wrap    = (pre_q == PRE_W'(SCAN_DIV - 1));
    frame_end   = pre_wrap && (idx_q == 3'd5);
    pre_d       = pre_wrap ? '0 : pre_q + PRE_W'(1);
    idx_d       = idx_q;
    frame_d     = frame_q;
    bp_d        = bp_q;
    snap_hour_d = snap_hour_q;
    snap_min_d  = snap_min_q;
    snap_sec_d  = snap_sec_q;
    snap_mask_d = snap_mask_q;
    if (pre_wrap) idx_d = frame_end ? 3'd0 : idx_q + 3'd1;
    if (frame_end) begin
      snap_hour_d = hour;
      snap_min_d  = min;
      snap_sec_d  = sec;
      snap_mask_d = blink_mask;
      if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_d = '0;
        bp_d    = ~bp_q;
      end else begin
        frame_d = frame_q + FRM_W'(1);
      end
    end
  end

  // Digit select and output encoding; polarity applied just before the output registers.
  always_comb begin
    nib      = snap_sec_q[3:0];
    mask_bit = snap_mask_q[5];
    case (idx_q)
      3'd0: begin nib = snap_hour_q[7:4]; mask_bit = snap_mask_q[0]; end
      3'd1: begin nib = snap_hour_q[3:0]; mask_bit = snap_mask_q[1]; end
      3'd2: begin nib = snap_min_q[7:4];  mask_bit = snap_mask_q[2]; end
      3'd3: begin nib = snap_min_q[3:0];  mask_bit = snap_mask_q[3]; end
      3'd4: begin nib = snap_sec_q[7:4];  mask_bit = snap_mask_q[4]; end
      default: ;
    endcase
    lit   = (pre_q >= PRE_W'(BLANK_CYC)) && !(bp_q && mask_bit);
    seg_d = (lit ? decode(nib) : 7'h00) ^ {7{INV}};
    dp_d  = (lit && colon_en && (idx_q == 3'd1 || idx_q == 3'd3)) ^ INV;
    an_d  = (lit ? (6'b000001 << idx_q) : 6'b000000) ^ {6{INV}};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q       <= '0;
      idx_q       <= 3'd0;
      frame_q     <= '0;
      bp_q        <= 1'b0;
      snap_hour_q <= 8'h00;
      snap_min_q  <= 8'h00;
      snap_sec_q  <= 8'h00;
      snap_mask_q <= 6'h00;
      seg_q       <= {7{INV}};
      dp_q        <= INV;
      an_q        <= {6{INV}};
    end else begin
      pre_q       <= pre_d;
      idx_q       <= idx_d;
      frame_q     <= frame_d;
      bp_q        <= bp_d;
      snap_hour_q <= snap_hour_d;
      snap_min_q  <= snap_min_d;
      snap_sec_q  <= snap_sec_d;
      snap_mask_q <= snap_mask_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      an_q        <= an_d;
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
  assign an  = an_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Self-checking bench for bcd_scan_display: arithmetic reference model plus scenario tasks.
module tb_bcd_scan_display;

  localparam int D     = 4;
  localparam int BL    = 1;
  localparam int BF    = 2;
  localparam int FRAME = 6 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] hour = 8'h00, min = 8'h00, sec = 8'h00;
  logic [5:0] blink_mask = 6'h00;
  logic       colon_en = 1'b0;
  logic [6:0] seg, seg1;
  logic       dp, dp1;
  logic [5:0] an, an1;

  int checks = 0;
  int errors = 0;

  bcd_scan_display #(.SCAN_DIV(D), .BLANK_CYC(BL), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec), .blink_mask(blink_mask),
    .colon_en(colon_en), .seg(seg), .dp(dp), .an(an));

  bcd_scan_display #(.SCAN_DIV(D), .BLANK_CYC(BL), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rst(rst), .hour(hour), .min(min), .sec(sec), .blink_mask(blink_mask),
    .colon_en(colon_en), .seg(seg1), .dp(dp1), .an(an1));

  always #5 clk = ~clk;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  // Reference model: k = clock edges since reset release; the output after edge k+1 reflects cycle k.
  int         k = 0;
  logic [7:0] sh = 8'h00, sm = 8'h00, ss = 8'h00;
  logic [5:0] smask = 6'h00;
  logic [6:0] exp_seg = 7'h00;
  logic       exp_dp = 1'b0;
  logic [5:0] exp_an = 6'h00;

  always @(posedge clk or posedge rst) begin
    int pre, idx, bp;
    logic [23:0] digits;
    logic [3:0]  nib;
    logic        lit;
    if (rst) begin
      k = 0; sh = 8'h00; sm = 8'h00; ss = 8'h00; smask = 6'h00;
      exp_seg = 7'h00; exp_dp = 1'b0; exp_an = 6'h00;
    end else begin
      pre    = k % D;
      idx    = (k / D) % 6;
      bp     = ((k / FRAME) / BF) % 2;
      digits = {sh, sm, ss};
      nib    = digits[23 - 4*idx -: 4];
      lit    = (pre >= BL) && !(bp == 1 && smask[idx]);
      exp_seg = lit ? dec_tab[nib] : 7'h00;
      exp_an  = lit ? 6'(1 << idx) : 6'h00;
      exp_dp  = lit && colon_en && (idx == 1 || idx == 3);
      if (k % FRAME == FRAME - 1) begin
        sh = hour; sm = min; ss = sec; smask = blink_mask;
      end
      k++;
    end
  end

  // Advance to the negedge whose output reflects the first cycle of a frame.
  task automatic align_frame();
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if ((k - 1) % FRAME == 0) break;
    end
  endtask

  task automatic settle();
    align_frame();
    align_frame();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({seg, dp, an} !== 14'h0000) begin
      errors++;
      $display("FAIL reset_al0 seg=%h dp=%b an=%h expected 00/0/00", seg, dp, an);
    end
    checks++;
    if ({seg1, dp1, an1} !== 14'h3FFF) begin
      errors++;
      $display("FAIL reset_al1 seg=%h dp=%b an=%h expected 7F/1/3F", seg1, dp1, an1);
    end
    hour = 8'h23; min = 8'h59; sec = 8'h58; colon_en = 1'b1; blink_mask = 6'h00;
    rst = 1'b0;
    for (int j = 0; j < FRAME; j++) begin
      @(negedge clk);
      checks++;
      if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an} || {seg1, dp1, an1} !== ~{exp_seg, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL first_frame_model j=%0d got %h/%b/%h inv %h/%b/%h expected %h/%b/%h",
                 j, seg, dp, an, seg1, dp1, an1, exp_seg, exp_dp, exp_an);
      end
      if (an !== 6'h00) begin
        checks++;
        if (seg !== 7'h3F) begin
          errors++;
          $display("FAIL first_frame_zero j=%0d seg=%h expected 3F", j, seg);
        end
      end
    end
  endtask

  task automatic test_steady();
    logic [6:0] tab [6] = '{7'h5B, 7'h4F, 7'h6D, 7'h6F, 7'h6D, 7'h7F};
    align_frame();
    for (int j = 0; j < FRAME; j++) begin
      int slot;
      logic [6:0] es;
      logic [5:0] ea;
      logic       ed;
      if (j > 0) @(negedge clk);
      slot = j / D;
      es = (j % D == 0) ? 7'h00 : tab[slot];
      ea = (j % D == 0) ? 6'h00 : 6'(1 << slot);
      ed = (j % D != 0) && (slot == 1 || slot == 3);
      checks++;
      if ({seg, dp, an} !== {es, ed, ea} || {seg1, dp1, an1} !== ~{es, ed, ea}) begin
        errors++;
        $display("FAIL steady j=%0d got %h/%b/%h inv %h/%b/%h expected %h/%b/%h",
                 j, seg, dp, an, seg1, dp1, an1, es, ed, ea);
      end
    end
  endtask

  task automatic test_tearing();
    logic [6:0] tab [6] = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
    hour = 8'h12; min = 8'h34; sec = 8'h56; colon_en = 1'b0; blink_mask = 6'h00;
    settle();
    for (int j = 0; j < 2 * FRAME; j++) begin
      int slot;
      logic [6:0] es;
      if (j > 0) @(negedge clk);
      slot = (j / D) % 6;
      es = (j % D == 0) ? 7'h00 : ((j < FRAME) ? tab[slot] : 7'h3F);
      checks++;
      if (seg !== es || an !== ((j % D == 0) ? 6'h00 : 6'(1 << slot)) || dp !== 1'b0
          || {seg1, dp1, an1} !== ~{exp_seg, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL tearing j=%0d got seg=%h an=%h dp=%b expected seg=%h slot=%0d", j, seg, an, dp, es, slot);
      end
      if (j == 9) begin
        hour = 8'h00; min = 8'h00; sec = 8'h00;
      end
    end
  endtask

  task automatic test_invalid_bcd();
    hour = 8'h3A; min = 8'h00; sec = 8'h00; blink_mask = 6'h00; colon_en = 1'b0;
    settle();
    for (int j = 0; j < 2 * D; j++) begin
      logic [6:0] es;
      if (j > 0) @(negedge clk);
      es = (j % D == 0) ? 7'h00 : ((j < D) ? 7'h4F : 7'h40);
      checks++;
      if (seg !== es || seg !== exp_seg || an !== exp_an) begin
        errors++;
        $display("FAIL invalid_bcd j=%0d seg=%h expected %h an=%h model an=%h", j, seg, es, an, exp_an);
      end
    end
  endtask

  task automatic test_blink();
    int m;
    hour = 8'h12; min = 8'h34; sec = 8'h56; colon_en = 1'b1; blink_mask = 6'b000011;
    settle();
    m = (k - 1) / FRAME;
    for (int f = 0; f < 4; f++) begin
      int lo, hi;
      lo = 0; hi = 0;
      for (int j = 0; j < FRAME; j++) begin
        if (j > 0 || f > 0) @(negedge clk);
        if (an[1:0] !== 2'b00) lo++;
        if (an[5:2] !== 4'b0000) hi++;
        checks++;
        if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an} || {seg1, dp1, an1} !== ~{exp_seg, exp_dp, exp_an}) begin
          errors++;
          $display("FAIL blink_model f=%0d j=%0d got %h/%b/%h expected %h/%b/%h",
                   f, j, seg, dp, an, exp_seg, exp_dp, exp_an);
        end
      end
      checks++;
      if (lo != ((((m + f) / BF) % 2 == 1) ? 0 : 2 * (D - BL)) || hi != 4 * (D - BL)) begin
        errors++;
        $display("FAIL blink_counts frame=%0d lo=%0d hi=%0d", m + f, lo, hi);
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 25; it++) begin
      int hold;
      hour = 8'($urandom); min = 8'($urandom); sec = 8'($urandom);
      blink_mask = 6'($urandom); colon_en = 1'($urandom);
      hold = $urandom_range(1, 40);
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        checks++;
        if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an} || {seg1, dp1, an1} !== ~{exp_seg, exp_dp, exp_an}) begin
          errors++;
          $display("FAIL random it=%0d j=%0d got %h/%b/%h inv %h/%b/%h expected %h/%b/%h",
                   it, j, seg, dp, an, seg1, dp1, an1, exp_seg, exp_dp, exp_an);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit found;
    hour = 8'h12; min = 8'h34; sec = 8'h56; colon_en = 1'b1; blink_mask = 6'h00;
    settle();
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (((k - 1) / D) % 6 == 3 && (k - 1) % D == 2) break;
    end
    checks++;
    if (an !== 6'b001000) begin
      errors++;
      $display("FAIL pre_reset_lit an=%h expected 08", an);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({seg, dp, an} !== 14'h0000 || {seg1, dp1, an1} !== 14'h3FFF) begin
      errors++;
      $display("FAIL async_reset got %h/%b/%h inv %h/%b/%h expected all off", seg, dp, an, seg1, dp1, an1);
    end
    @(negedge clk);
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      checks++;
      if ({seg, dp, an} !== {exp_seg, exp_dp, exp_an} || {seg1, dp1, an1} !== ~{exp_seg, exp_dp, exp_an}) begin
        errors++;
        $display("FAIL post_reset_model i=%0d got %h/%b/%h expected %h/%b/%h", i, seg, dp, an, exp_seg, exp_dp, exp_an);
      end
      if (an !== 6'h00) begin
        found = 1'b1;
        checks++;
        if (an !== 6'h01 || seg !== 7'h3F) begin
          errors++;
          $display("FAIL post_reset_first an=%h seg=%h expected 01/3F", an, seg);
        end
      end
    end
    if (!found) begin
      errors++;
      $display("FAIL post_reset_timeout no lit digit within 40 cycles");
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_tearing();
    test_invalid_bcd();
    test_blink();
    test_random();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed 6-digit 7-segment driver that reads the packed 8421-BCD hour/minute/second values produced by the clock's counter chain and presents them on a shared segment bus. It sits between the time-keeping counters and the board's display pins. It snapshots the time once per scan frame so a digit pair never tears mid-frame. It also provides per-digit blinking for time-setting mode, a colon decimal point, inter-digit ghost blanking, and an error glyph for non-BCD nibbles.

## Interface
Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (≥2).
- BLANK_CYC, 500: cycles at the start of each slot with all anodes off (0 ≤ BLANK_CYC < SCAN_DIV).
- BLINK_FRAMES, 60: frames per blink half-period (≥1).
- ACTIVE_LOW, 1: 1 inverts seg, dp and an at the output registers (common-anode board).

Ports:
- clk  in  1  system clock; the block has one clock, clk.
- rst  in  1  asynchronous, active-high reset.
- hour  in  8  BCD hours, [7:4] tens, [3:0] ones.
- min  in  8  BCD minutes.
- sec  in  8  BCD seconds.
- blink_mask  in  6  bit i=1 makes digit i blink.
- colon_en  in  1  enables dp on digits 1 and 3.
- seg  out  7  segments {g,f,e,d,c,b,a}.
- dp  out  1  decimal point.
- an  out  6  digit enables, one-hot when active; an[0] is the leftmost digit (hour tens).

## Operation
- Digit order by index 0..5: hour[7:4], hour[3:0], min[7:4], min[3:0], sec[7:4], sec[3:0].
- Prescaler pre counts 0..SCAN_DIV-1 and wraps. On wrap, digit index idx advances 0→5, then wraps to 0.
- Snapshot: hour, min, sec and blink_mask are latched into internal registers on the cycle idx wraps 5→0. No other input change is visible until the next frame. colon_en is used live.
- Frame counter counts completed frames 0..BLINK_FRAMES-1. On wrap, blink phase bp toggles.
- Decode, active-high before polarity is applied: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F. Any nibble A–F decodes to 40 (dash).
- Digit idx is lit when pre ≥ BLANK_CYC and !(bp && snap_mask[idx]). Otherwise an is all-off and seg/dp are all-off.
- When lit, an has a one-hot at bit idx and seg shows the decoded nibble. dp = colon_en && (idx==1 || idx==3).
- Reset values, all state: pre=0, idx=0, frame=0, bp=0, snapshot=0. Outputs are all off: seg/dp/an = 0 when ACTIVE_LOW=0, all ones when ACTIVE_LOW=1.

## Timing
- seg, dp and an are registered. Their value at edge t+1 reflects pre, idx, bp and snapshot at edge t: one-cycle latency.
- One slot = SCAN_DIV cycles: BLANK_CYC cycles dark, then SCAN_DIV-BLANK_CYC cycles lit. One frame = 6·SCAN_DIV cycles.
- The first frame after reset release displays the reset snapshot (zeros → "000000"). Live inputs appear from the second frame.
- A snapshot taken at the 5→0 wrap is displayed starting with that same slot 0.
- Async reset mid-frame: outputs go to their off value immediately, without a clock edge. Scanning restarts at idx 0, pre 0 on the first edge after release.
- blink_mask=000000 makes bp have no visible effect. blink_mask=111111 blanks the whole display for alternate BLINK_FRAMES-frame periods.

## Test plan
All scenarios use SCAN_DIV=4, BLANK_CYC=1, BLINK_FRAMES=2, ACTIVE_LOW=0 unless stated.
- Reset: hold rst → seg=00, dp=0, an=00. Repeat with ACTIVE_LOW=1 → seg=7F, dp=1, an=3F. Assert rst asynchronously between edges → outputs change without a clock edge.
- Steady display: hour=23, min=59, sec=58, colon_en=1, from the second frame onward → per slot, 1 dark cycle then 3 cycles of an=01/02/04/08/10/20 with seg=5B,4F,6D,6F,6D,7F. dp=1 only while an=02 and an=08.
- Tearing: 12:34:56 displayed, change inputs to 00:00:00 while idx=2 → slots 2–5 still show 3,4,5,6 (4F,66,6D,7D). The next frame shows 3F on every digit.
- Invalid BCD: hour=3A → digit 1 seg=40; digit 0 seg=4F.
- Blink: blink_mask=000011 → frames alternate two visible, two with an[1:0] never asserted. Digits 2–5 are unaffected.
- Reset mid-frame: assert rst during idx=3, release → first lit output after release is an=01 with seg=3F (zero snapshot).
